// File: rtl/vga_disp_pipe.sv
// Parametrised VGA scan-out: programmable timing, framebuffer read with latency re-alignment, pixel replication.
// Optional colour-bar generator enabled by defining VGA_DISP_TESTPAT_EN.
module vga_disp_pipe #(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned H_FP        = 16,
  parameter int unsigned H_SYNC      = 96,
  parameter int unsigned H_BP        = 48,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned V_FP        = 10,
  parameter int unsigned V_SYNC      = 2,
  parameter int unsigned V_BP        = 33,
  parameter int unsigned COLOR_W     = 8,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned SCALE_SHIFT = 0,
  parameter int unsigned SYNC_POL    = 0
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         en,
`ifdef VGA_DISP_TESTPAT_EN
  input  logic                                         testpat,
`endif
  output logic                                         fb_rd,
  output logic [$clog2(H_ACTIVE>>SCALE_SHIFT)-1:0]     fb_addr_h,
  output logic [$clog2(V_ACTIVE>>SCALE_SHIFT)-1:0]     fb_addr_v,
  input  logic [3*COLOR_W-1:0]                         fb_data,
  output logic                                         VGA_HSYNC,
  output logic                                         VGA_VSYNC,
  output logic                                         VGA_BLANK_N,
  output logic [COLOR_W-1:0]                           VGA_R,
  output logic [COLOR_W-1:0]                           VGA_G,
  output logic [COLOR_W-1:0]                           VGA_B,
  output logic                                         frame_start,
  output logic                                         line_start
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HC_W    = $clog2(H_TOTAL);
  localparam int unsigned VC_W    = $clog2(V_TOTAL);
  localparam int unsigned AH_W    = $clog2(H_ACTIVE >> SCALE_SHIFT);
  localparam int unsigned AV_W    = $clog2(V_ACTIVE >> SCALE_SHIFT);
  localparam int unsigned RGB_W   = 3 * COLOR_W;
  localparam int unsigned HS_BEG  = H_ACTIVE + H_FP;
  localparam int unsigned HS_END  = HS_BEG + H_SYNC;
  localparam int unsigned VS_BEG  = V_ACTIVE + V_FP;
  localparam int unsigned VS_END  = VS_BEG + V_SYNC;
  localparam logic        SYNC_ACT = 1'(SYNC_POL);

  // Alignment pipeline bit positions
  localparam int unsigned P_ACT = 0;
  localparam int unsigned P_HS  = 1;
  localparam int unsigned P_VS  = 2;
  localparam int unsigned P_LS  = 3;
  localparam int unsigned P_FS  = 4;
`ifdef VGA_DISP_TESTPAT_EN
  localparam int unsigned P_PAT  = 5;
  localparam int unsigned P_BAR  = 6;
  localparam int unsigned PIPE_W = P_BAR + RGB_W;
`else
  localparam int unsigned PIPE_W = 5;
`endif

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [HC_W-1:0]   h_q, h_d;
  logic [VC_W-1:0]   v_q, v_d;
  logic              h_last, v_last, running;
  logic              active_c, hs_c, vs_c, ls_c, fs_c;
  logic [PIPE_W-1:0] pipe_in, pipe_out;
  logic [RGB_W-1:0]  pix_data;

  assign h_last  = (h_q == HC_W'(H_TOTAL - 1));
  assign v_last  = (v_q == VC_W'(V_TOTAL - 1));
  assign running = (state_q == RUN);

  // State and scan counters
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      h_q     <= '0;
      v_q     <= '0;
    end else begin
      state_q <= state_d;
      h_q     <= h_d;
      v_q     <= v_d;
    end
  end

  // Next state: en only matters in IDLE or on the last pixel of a frame
  always_comb begin
    state_d = state_q;
    h_d     = h_q;
    v_d     = v_q;
    case (state_q)
      IDLE: begin
        h_d = '0;
        v_d = '0;
        if (en) state_d = RUN;
      end
      RUN: begin
        if (h_last) begin
          h_d = '0;
          if (v_last) begin
            v_d = '0;
            if (!en) state_d = IDLE;
          end else begin
            v_d = v_q + VC_W'(1);
          end
        end else begin
          h_d = h_q + HC_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Timing decode from the counters
  always_comb begin
    active_c = running && (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    hs_c     = running && (32'(h_q) >= HS_BEG) && (32'(h_q) < HS_END);
    vs_c     = running && (32'(v_q) >= VS_BEG) && (32'(v_q) < VS_END);
    ls_c     = running && (h_q == '0) && (32'(v_q) < V_ACTIVE);
    fs_c     = running && (h_q == '0) && (v_q == '0);
  end

`ifdef VGA_DISP_TESTPAT_EN
  logic       pat_q;
  logic [2:0] bar_idx;
  logic [RGB_W-1:0] bar_rgb;

  // Test-pattern select latched at frame boundaries, like en
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                          pat_q <= 1'b0;
    else if (!running || (h_last && v_last)) pat_q <= testpat;
  end

  // Bars: white, yellow, cyan, green, magenta, red, blue, black
  always_comb begin
    bar_idx = 3'((32'(h_q) * 32'd8) / H_ACTIVE);
    bar_rgb = {{COLOR_W{~bar_idx[1]}}, {COLOR_W{~bar_idx[2]}}, {COLOR_W{~bar_idx[0]}}};
    pipe_in = {bar_rgb, pat_q, fs_c, ls_c, vs_c, hs_c, active_c};
    fb_rd   = active_c && !pat_q;
  end
`else
  always_comb begin
    pipe_in = {fs_c, ls_c, vs_c, hs_c, active_c};
    fb_rd   = active_c;
  end
`endif

  assign fb_addr_h = fb_rd ? AH_W'(h_q >> SCALE_SHIFT) : '0;
  assign fb_addr_v = fb_rd ? AV_W'(v_q >> SCALE_SHIFT) : '0;

  // Delay timing flags to match the framebuffer read latency
  generate
    if (RD_LAT == 0) begin : g_nodly
      assign pipe_out = pipe_in;
    end else begin : g_dly
      logic [PIPE_W-1:0] dly_q [RD_LAT];
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < int'(RD_LAT); i++) dly_q[i] <= '0;
        end else begin
          dly_q[0] <= pipe_in;
          for (int i = 1; i < int'(RD_LAT); i++) dly_q[i] <= dly_q[i-1];
        end
      end
      assign pipe_out = dly_q[RD_LAT-1];
    end
  endgenerate

`ifdef VGA_DISP_TESTPAT_EN
  assign pix_data = pipe_out[P_PAT] ? pipe_out[PIPE_W-1:P_BAR] : fb_data;
`else
  assign pix_data = fb_data;
`endif

  // Registered pins; colour forced to zero outside the visible area
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      VGA_HSYNC   <= ~SYNC_ACT;
      VGA_VSYNC   <= ~SYNC_ACT;
      VGA_BLANK_N <= 1'b0;
      VGA_R       <= '0;
      VGA_G       <= '0;
      VGA_B       <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
    end else begin
      VGA_HSYNC   <= pipe_out[P_HS] ? SYNC_ACT : ~SYNC_ACT;
      VGA_VSYNC   <= pipe_out[P_VS] ? SYNC_ACT : ~SYNC_ACT;
      VGA_BLANK_N <= pipe_out[P_ACT];
      {VGA_R, VGA_G, VGA_B} <= pipe_out[P_ACT] ? pix_data : '0;
      frame_start <= pipe_out[P_FS];
      line_start  <= pipe_out[P_LS];
    end
  end

endmodule

// File: tb/tb_vga_disp_pipe.sv
// Bench for vga_disp_pipe: two instances (deep latency + 2x scaling / zero latency + high syncs)
// checked every clock against a position-based reference model.
module tb_vga_disp_pipe;

  localparam int HA = 32, HFP = 4, HSW = 6, HBP = 6;
  localparam int VA = 16, VFP = 2, VSW = 2, VBP = 3;
  localparam int HT = HA + HFP + HSW + HBP;
  localparam int VT = VA + VFP + VSW + VBP;
  localparam int FT = HT * VT;
  localparam int LA = 3, SA = 1, LB = 0, SB = 0;
  localparam bit PA = 1'b0, PB = 1'b1;
  localparam logic [23:0] JUNK = 24'hC3A55A;

  logic clk = 1'b0;
  logic rst, en;
  logic [23:0] salt;

  logic       a_rd, a_hs, a_vs, a_bn, a_fs, a_ls;
  logic [3:0] a_ah;
  logic [2:0] a_av;
  logic [7:0] a_r, a_g, a_b;
  logic [23:0] a_fb, a_pix, a_d1, a_d2, a_d3;
  logic       b_rd, b_hs, b_vs, b_bn, b_fs, b_ls;
  logic [4:0] b_ah;
  logic [3:0] b_av;
  logic [7:0] b_r, b_g, b_b;
  logic [23:0] b_fb;
  logic [28:0] a_obs, b_obs;

  int checks = 0;
  int errors = 0;
  int m_pos = -1;
  int hist [8];

  always #5 clk = ~clk;

  vga_disp_pipe #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .COLOR_W(8), .RD_LAT(LA), .SCALE_SHIFT(SA), .SYNC_POL(0)
  ) dut_a (
    .clk(clk), .rst(rst), .en(en), .fb_rd(a_rd), .fb_addr_h(a_ah), .fb_addr_v(a_av),
    .fb_data(a_fb), .VGA_HSYNC(a_hs), .VGA_VSYNC(a_vs), .VGA_BLANK_N(a_bn),
    .VGA_R(a_r), .VGA_G(a_g), .VGA_B(a_b), .frame_start(a_fs), .line_start(a_ls)
  );

  vga_disp_pipe #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .COLOR_W(8), .RD_LAT(LB), .SCALE_SHIFT(SB), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(en), .fb_rd(b_rd), .fb_addr_h(b_ah), .fb_addr_v(b_av),
    .fb_data(b_fb), .VGA_HSYNC(b_hs), .VGA_VSYNC(b_vs), .VGA_BLANK_N(b_bn),
    .VGA_R(b_r), .VGA_G(b_g), .VGA_B(b_b), .frame_start(b_fs), .line_start(b_ls)
  );

  function automatic logic [23:0] pix(input int x, input int y);
    return {8'(x) ^ salt[23:16], 8'(y) ^ salt[15:8], 8'h5A ^ salt[7:0]};
  endfunction

  // Framebuffer models: junk when not read, so blank masking is visible
  always_comb begin
    a_pix = a_rd ? pix(int'(a_ah), int'(a_av)) : JUNK;
    b_fb  = b_rd ? pix(int'(b_ah), int'(b_av)) : JUNK;
    a_obs = {a_hs, a_vs, a_bn, a_fs, a_ls, a_r, a_g, a_b};
    b_obs = {b_hs, b_vs, b_bn, b_fs, b_ls, b_r, b_g, b_b};
  end

  always @(posedge clk) begin
    a_d1 <= a_pix;
    a_d2 <= a_d1;
    a_d3 <= a_d2;
  end
  assign a_fb = a_d3;

  // Expected pins for a scan position p (pixels into the frame; -1 = idle)
  function automatic logic [28:0] exp_pins(input int p, input int s, input bit pol);
    bit act, hs, vs, fs, ls;
    int x, y;
    logic [23:0] rgb;
    act = 0; hs = 0; vs = 0; fs = 0; ls = 0; rgb = '0;
    if (p >= 0) begin
      x = p % HT;
      y = p / HT;
      act = (x < HA) && (y < VA);
      hs  = (x >= HA + HFP) && (x < HA + HFP + HSW);
      vs  = (y >= VA + VFP) && (y < VA + VFP + VSW);
      ls  = (x == 0) && (y < VA);
      fs  = (p == 0);
      if (act) rgb = pix(x >> s, y >> s);
    end
    return {hs ? pol : !pol, vs ? pol : !pol, act, fs, ls, rgb};
  endfunction

  function automatic logic [20:0] exp_fb(input int p, input int s);
    int x, y;
    if (p < 0) return '0;
    x = p % HT;
    y = p / HT;
    if (x < HA && y < VA) return {1'b1, 10'(x >> s), 10'(y >> s)};
    return '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("a_pins", 32'(a_obs), 32'(exp_pins(hist[LA+1], SA, PA)));
    chk("b_pins", 32'(b_obs), 32'(exp_pins(hist[LB+1], SB, PB)));
    chk("a_fb", 32'({a_rd, 10'(a_ah), 10'(a_av)}), 32'(exp_fb(hist[0], SA)));
    chk("b_fb", 32'({b_rd, 10'(b_ah), 10'(b_av)}), 32'(exp_fb(hist[0], SB)));
  endtask

  // One clock: advance the model's scan position, then compare
  task automatic tick();
    @(posedge clk);
    if (!rst)                m_pos = -1;
    else if (m_pos < 0)      m_pos = en ? 0 : -1;
    else if (m_pos == FT-1)  m_pos = en ? 0 : -1;
    else                     m_pos = m_pos + 1;
    for (int i = 7; i > 0; i--) hist[i] = rst ? hist[i-1] : -1;
    hist[0] = m_pos;
    #1;
    check_all();
  endtask

  task automatic async_reset();
    #2 rst = 1'b0;
    m_pos = -1;
    for (int i = 0; i < 8; i++) hist[i] = -1;
    #1;
    check_all();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, nb, nl, w, target, stray;
    salt = 24'($urandom);
    for (int i = 0; i < 8; i++) hist[i] = -1;
    rst = 1'b0;
    en  = 1'b0;
    repeat (4) tick();
    chk("rst_hs_a", 32'(a_hs), 32'(!PA));
    chk("rst_hs_b", 32'(b_hs), 32'(!PB));

    // Release with en high; first frame_start RD_LAT+1 clocks after the RUN entry edge
    rst = 1'b1;
    en  = 1'b1;
    tick();
    n = 0; nb = -1;
    do begin
      tick(); n++;
      if (b_fs === 1'b1 && nb < 0) nb = n;
    end while (a_fs !== 1'b1 && n < 40);
    chk("first_fs_a", 32'(n), 32'(LA + 1));
    chk("first_fs_b", 32'(nb), 32'(LB + 1));
    chk("bn_with_fs", 32'(a_bn), 32'd1);

    n = 0; nl = -1;
    do begin
      tick(); n++;
      if (a_ls === 1'b1 && nl < 0) nl = n;
    end while (a_fs !== 1'b1 && n < FT + 50);
    chk("line_period", 32'(nl), 32'(HT));
    chk("frame_period", 32'(n), 32'(FT));

    n = 0;
    while (a_hs !== PA && n < 2*HT) begin tick(); n++; end
    chk("hs_offset", 32'(n), 32'(HA + HFP));
    chk("hs_pol_b", 32'(b_hs), 32'(PB));
    w = 0;
    while (a_hs === PA && w < HT) begin tick(); w++; end
    chk("hs_width", 32'(w), 32'(HSW));

    n = 0;
    while (a_fs !== 1'b1 && n < FT + 50) begin tick(); n++; end
    n = 0;
    while (a_vs !== PA && n < FT) begin tick(); n++; end
    chk("vs_offset", 32'(n), 32'((VA + VFP) * HT));
    w = 0;
    while (a_vs === PA && w < FT) begin tick(); w++; end
    chk("vs_width", 32'(w), 32'(VSW * HT));

    // Random en: only frame-boundary values may matter
    repeat (2*FT) begin
      en = 1'($urandom_range(0, 1));
      tick();
    end

    // Drop en mid-frame: frame completes, then idle
    en = 1'b1;
    n = 0;
    while (m_pos < 0 && n < FT + 10) begin tick(); n++; end
    target = $urandom_range(1, VT - 2) * HT + $urandom_range(0, HT - 1);
    n = 0;
    while (m_pos != target && n < 2*FT) begin tick(); n++; end
    en = 1'b0;
    n = 0;
    while (m_pos >= 0 && n < FT + 10) begin tick(); n++; end
    repeat (LA + 3) tick();
    chk("idle_hs_a", 32'(a_hs), 32'(!PA));
    chk("idle_vs_b", 32'(b_vs), 32'(!PB));
    chk("idle_bn_a", 32'(a_bn), 32'd0);
    chk("idle_rd_a", 32'(a_rd), 32'd0);

    en = 1'b1;
    tick();
    chk("restart_rd", 32'(a_rd), 32'd1);
    chk("restart_addr", 32'({b_ah, b_av}), 32'd0);

    // Asynchronous reset in the middle of a visible line
    target = $urandom_range(1, VA - 1) * HT + $urandom_range(1, HA - 1);
    n = 0;
    while (m_pos != target && n < 2*FT) begin tick(); n++; end
    async_reset();
    en = 1'b0;
    chk("rst_now_a", 32'(a_obs), 32'({!PA, !PA, 27'd0}));
    chk("rst_now_b", 32'(b_obs), 32'({!PB, !PB, 27'd0}));
    repeat (3) tick();
    rst = 1'b1;
    stray = 0;
    repeat (3*HT) begin
      tick();
      if (a_hs !== !PA || b_hs !== !PB || a_bn !== 1'b0) stray++;
    end
    chk("no_stray", 32'(stray), 32'd0);

    en = 1'b1;
    repeat (FT + 200) begin
      if ($urandom_range(0, 7) == 0) en = ~en;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_disp_pipe.md
Name: vga_disp_pipe

Overview:
- Parametrised VGA scan-out engine for the display experiments; successor to the fixed 640x480 display top.
- Generates programmable H/V timing and issues pixel reads to an external framebuffer/ROM with configurable read latency.
- Re-aligns syncs and blank to the returned data; supports integer pixel replication (2^SCALE_SHIFT) so small images fill the screen.
- Sits between the framebuffer/picture ROM and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (clocks)
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- COLOR_W, 8, bits per colour channel
- RD_LAT, 1, framebuffer read latency in clocks, legal 0..4
- SCALE_SHIFT, 0, replication factor 2^SCALE_SHIFT in both axes, legal 0..3
- SYNC_POL, 0, 0 = sync pulses active-low, 1 = active-high

Ports:
- clk  in  1  pixel clock
- rst  in  1  asynchronous, active-low reset
- en  in  1  display enable, sampled only at frame boundary
- fb_rd  out  1  read strobe, high while in the active region
- fb_addr_h  out  $clog2(H_ACTIVE>>SCALE_SHIFT)  framebuffer column
- fb_addr_v  out  $clog2(V_ACTIVE>>SCALE_SHIFT)  framebuffer row
- fb_data  in  3*COLOR_W  {R,G,B}, valid RD_LAT clocks after fb_rd
- VGA_HSYNC  out  1  horizontal sync
- VGA_VSYNC  out  1  vertical sync
- VGA_BLANK_N  out  1  high during visible pixels
- VGA_R, VGA_G, VGA_B  out  COLOR_W each  pixel colour
- frame_start  out  1  one-clock pulse on the first visible pixel of a frame, pin-aligned
- line_start  out  1  one-clock pulse on the first visible pixel of each line, pin-aligned

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise.
- Line order: active, front porch, sync, back porch, in both axes.
- h_cnt runs 0..H_TOTAL-1 and wraps to 0. v_cnt increments on h wrap and runs 0..V_TOTAL-1.
- Active region: h_cnt<H_ACTIVE && v_cnt<V_ACTIVE.
- Address generation is combinational from the counters:
  - fb_rd = running && active
  - fb_addr_h = h_cnt>>SCALE_SHIFT, fb_addr_v = v_cnt>>SCALE_SHIFT
  - Both addresses read 0 when fb_rd is low.
- Alignment pipeline: active, hsync, vsync, line_start and frame_start are delayed through an RD_LAT-deep shift register. With RD_LAT=0, fb_data is treated as combinational.
- Pin outputs are registered. Pin latency = RD_LAT+1 clocks after the counter state that produced them. All pin outputs are mutually aligned.
- RGB pins = fb_data when delayed-active, otherwise 0. Colour is never driven during blank.
- States:
  - IDLE: counters held at 0, fb_rd=0, syncs inactive, BLANK_N=0, RGB=0.
  - RUN: counting.
- Transitions:
  - IDLE->RUN on the first clock with en=1. The pin for counter (0,0) appears RD_LAT+1 clocks later.
  - RUN->IDLE only when en=0 at h_cnt=H_TOTAL-1 && v_cnt=V_TOTAL-1. Deasserting en mid-frame completes the frame.
- Pipeline drain on entering IDLE: in-flight pixel stages still reach the pins; the pipeline then shifts in blank.
- Reset (asynchronous, any time, including mid-line):
  - State IDLE, counters 0, shift registers cleared.
  - VGA_HSYNC/VGA_VSYNC at inactive level (~SYNC_POL), BLANK_N=0, RGB=0, pulses 0, fb_rd=0.
  - No glitch pulse on release.
- Widths: counters sized $clog2(H_TOTAL) / $clog2(V_TOTAL). No arithmetic overflow possible.

Optional Feature:
- Macro: VGA_DISP_TESTPAT_EN.
- When defined:
  - Extra input port testpat (1 bit), sampled at frame boundary like en.
  - When active, RGB comes from internal 8-bar colour bars: bar index = h_cnt*8/H_ACTIVE, order white, yellow, cyan, green, magenta, red, blue, black, full-scale values.
  - Colour-bar data is pipelined through the same RD_LAT alignment.
  - fb_rd is forced 0.
- When undefined: no testpat port and no bar logic.

Test Plan:
- Default params, rst low, then release with en=1: first frame_start at clock RD_LAT+1=2; BLANK_N rises with it; line period 800 clocks, frame period 420000 clocks.
- Sync check: HSYNC low for exactly 96 clocks starting 656 clocks after line_start; VSYNC low for 2 lines starting at line 490. Repeat with SYNC_POL=1 and confirm inverted polarity.
- RD_LAT=3, fb_data = {addr_h[7:0], addr_v[7:0], 8'h5A} model with 3-clock delay: pin pixel (x,y) shows R=x[7:0], G=y[7:0]; blank pixels are 0; sweep RD_LAT 0..4.
- SCALE_SHIFT=1: fb_addr_h sequence 0,0,1,1,...,319,319; fb_addr_v repeats each row for 2 lines; max row 239.
- en dropped at line 100: frame completes to line 524; then IDLE with syncs inactive; re-raise en and restart at (0,0).
- rst asserted at h_cnt=300 of line 50: all outputs reset level in the same cycle; no stray HSYNC pulse after release with en=0.
